iter_shifter: RTL and testbench

//  Multi-cycle 16-bit shift/rotate unit for the ALU. It shifts one bit per cycle under a start/done handshake.

---
 rtl/iter_shifter_pkg.sv | 19 +
 rtl/iter_shifter_shl1_step.sv | 12 +
 rtl/iter_shifter.sv | 107 ++++++++++
 tb/tb_iter_shifter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared constants for the iterative shift/rotate unit: default sizes,
// operation codes and FSM state encodings.
package iter_shifter_pkg;

    localparam int IS_WIDTH = 16;
    localparam int IS_AMT_W = 4;

    // Operation codes; op[1] selects the bit-reversed (right-shift) path.
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // FSM state encodings; 2'b11 is unreachable and recovers to idle.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SHIFT  = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

endpackage

// File: rtl/iter_shifter_shl1_step.sv
// One-bit left shift with an injected fill bit at the LSB.
module shl1_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out
);

    assign data_out = {data_in[WIDTH-2:0], fill};

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit. Only a left datapath exists; right
// operations bit-reverse the operand going in and the result coming out.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = IS_WIDTH,
    parameter int AMT_W = IS_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             sign_q;
    logic             fill;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] work_rev;

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    // Bit-reversal networks for the operand and the finished work register.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bitrev
        assign a_rev[i]    = a[WIDTH-1-i];
        assign work_rev[i] = work[WIDTH-1-i];
    end

    // Busy covers every non-idle state, including the finish edge.
    assign busy = (state != ST_IDLE);

    // Fill bit: rotates recirculate the MSB, SRA replicates the sign
    // (which lands at the reversed LSB), SLL shifts in zero.
    always_comb begin
        fill = 1'b0;
        case (op_q)
            OP_ROL:  fill = work[WIDTH-1];
            OP_ROR:  fill = work[WIDTH-1];
            OP_SLL:  fill = 1'b0;
            OP_SRA:  fill = sign_q;
            default: fill = 1'b0;
        endcase
    end

    shl1_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data_in (work),
        .fill    (fill),
        .data_out(shifted)
    );

    // Control FSM and datapath registers; done is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            result <= {WIDTH{1'b0}};
            work   <= {WIDTH{1'b0}};
            cnt    <= {AMT_W{1'b0}};
            op_q   <= 2'b00;
            sign_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_q <= a[WIDTH-1];
                        cnt    <= amt;
                        work   <= op[1] ? a_rev : a;
                        state  <= (amt == {AMT_W{1'b0}}) ? ST_FINISH : ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_FINISH;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end
                ST_FINISH: begin
                    result <= op_q[1] ? work_rev : work;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: the driver queues expected results
// with their expected completion edge; a monitor checks every done pulse.
module tb_iter_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] value;
        int          edge_no;
        string       name;
    } exp_t;

    exp_t sb[$];

    iter_shifter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: count edges, compare each done pulse against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done at edge %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, {16'h0000, result}, {16'h0000, e.value});
                    check({e.name, "_latency"}, cyc, e.edge_no);
                end
            end
        end
    end

    // Called at a negedge with the DUT idle or in its done cycle.
    task automatic issue(input string name, input logic [1:0] o, input logic [15:0] d,
                         input logic [3:0] n, input logic [15:0] exp_val);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = d;
        amt   = n;
        e.value   = exp_val;
        e.edge_no = cyc + 1 + int'(n) + 1;
        e.name    = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 2'b00;
        a     = 16'h0000;
        amt   = 4'd0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic count_busy(input string name, input int req);
        int n;
        n = 1;  // caller returns at the negedge after the accepting edge
        check({name, "_busy_start"}, {31'd0, busy}, 32'd1);
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        check({name, "_busy_cycles"}, n, req);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 16'h0000;
        amt   = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'h0000, result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic function vectors
        issue("rol_8001_1", 2'b00, 16'h8001, 4'd1, 16'h0003);
        drain();
        issue("sra_8000_15", 2'b11, 16'h8000, 4'd15, 16'hFFFF);
        count_busy("sra_8000_15", 16);
        drain();
        issue("sra_4000_14", 2'b11, 16'h4000, 4'd14, 16'h0001);
        drain();
        issue("ror_0001_4", 2'b10, 16'h0001, 4'd4, 16'h1000);
        drain();
        issue("sll_abcd_4", 2'b01, 16'hABCD, 4'd4, 16'hBCD0);
        drain();
        issue("ror_8421_15", 2'b10, 16'h8421, 4'd15, 16'h0843);
        drain();

        // Zero amount: one edge of busy
        issue("sll_abcd_0", 2'b01, 16'hABCD, 4'd0, 16'hABCD);
        count_busy("sll_abcd_0", 1);
        drain();

        // Start while busy is ignored; start in done cycle is accepted
        issue("rol_0001_3", 2'b00, 16'h0001, 4'd3, 16'h0008);
        start = 1'b1;
        op    = 2'b01;
        a     = 16'hFFFF;
        amt   = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("b2b_done_cycle_done", {31'd0, done}, 32'd1);
        check("b2b_done_cycle_busy", {31'd0, busy}, 32'd0);
        issue("b2b_sra_f0f0_4", 2'b11, 16'hF0F0, 4'd4, 16'hFF0F);
        check("b2b_result_held", {16'h0000, result}, 32'h0000_0008);
        drain();

        // Reset mid-shift aborts the operation
        issue("abort_sll_10", 2'b01, 16'h1234, 4'd10, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {16'h0000, result}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_late_done", {31'd0, done}, 32'd0);
        issue("post_rst_rol_c003_2", 2'b00, 16'hC003, 4'd2, 16'h000F);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
